// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator stack controller.
package rpn_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, WRITE} state_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h6;

    localparam int K_PUSH = 0;
    localparam int K_POP  = 1;
    localparam int K_EXEC = 2;
    localparam int K_SWAP = 3;

    function automatic logic [3:0] mode_to_op(input logic [1:0] mode);
        case (mode)
            2'b00:   return OP_ADD;
            2'b01:   return OP_SUB;
            2'b10:   return OP_AND;
            default: return OP_OR;
        endcase
    endfunction

endpackage

// File: rtl/rpn_stack_ctrl_key_edge.sv
// Synchronizes the active-low pushbuttons and emits a one-cycle pulse per press.
module key_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [3:0] press
);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] prev;

    // Reset to the released level so a button already held at reset is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
            press <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
            press <= prev & ~sync2;
        end
    end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN operand stack and command FSM; drives the shared ALU for arithmetic.
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [3:0]       key,
    input  logic [WIDTH-1:0] val,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    output logic [4:0]       alu_shamt,
    input  logic [31:0]      alu_lo,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [7:0]       counter,
    output logic             busy,
    output logic             err
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [7:0]       sp;
    logic [AW-1:0]    i_top;
    logic [AW-1:0]    i_next;
    logic [WIDTH-1:0] result;
    logic [3:0]       press;
    state_t           state;
    state_t           state_d;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             do_load;
    logic             do_write;
    logic             rejected;
    logic             unused_alu_hi;

    key_edge u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (press)
    );

    assign i_top     = AW'(sp - 8'd1);
    assign i_next    = AW'(sp - 8'd2);
    assign top       = (sp != 8'd0) ? mem[i_top] : '0;
    assign next      = (sp >= 8'd2) ? mem[i_next] : '0;
    assign counter   = sp;
    assign alu_shamt = 5'd0;
    assign unused_alu_hi = ^alu_lo[31:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Priority chain gives push > pop > execute > swap when presses coincide.
    always_comb begin
        state_d  = state;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_swap  = 1'b0;
        do_load  = 1'b0;
        do_write = 1'b0;
        rejected = 1'b0;
        case (state)
            IDLE: begin
                if (press[K_PUSH]) begin
                    if (sp < DEPTH_C) do_push = 1'b1;
                    else              rejected = 1'b1;
                end else if (press[K_POP]) begin
                    if (sp != 8'd0) do_pop = 1'b1;
                    else            rejected = 1'b1;
                end else if (press[K_EXEC]) begin
                    if (sp >= 8'd2) begin
                        do_load = 1'b1;
                        state_d = LOAD;
                    end else begin
                        rejected = 1'b1;
                    end
                end else if (press[K_SWAP]) begin
                    if (sp >= 8'd2) do_swap = 1'b1;
                    else            rejected = 1'b1;
                end
            end
            LOAD:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE: begin
                state_d  = IDLE;
                do_write = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp     <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= OP_ADD;
            result <= '0;
        end else begin
            busy <= (state_d != IDLE);
            if (do_push)
                sp <= sp + 8'd1;
            else if (do_pop || do_write)
                sp <= sp - 8'd1;
            if (rejected)
                err <= 1'b1;
            else if (do_push || do_pop || do_swap || do_load)
                err <= 1'b0;
            if (do_load) begin
                alu_a  <= 32'(next);
                alu_b  <= 32'(top);
                alu_op <= mode_to_op(mode);
            end
            if (state == LOAD)
                result <= alu_lo[WIDTH-1:0];
        end
    end

    // Storage is deliberately not reset; sp alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[AW'(sp)] <= val;
        if (do_swap) begin
            mem[i_top]  <= mem[i_next];
            mem[i_next] <= mem[i_top];
        end
        if (do_write)
            mem[i_next] <= result;
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: directed vector table, corner sequences, random vs queue model.
module tb_rpn_stack_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  key;
    logic [15:0] val;
    logic [31:0] alu_a, alu_b, alu_lo;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [15:0] top, next;
    logic [7:0]  counter;
    logic        busy, err;

    rpn_stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .mode(mode), .key(key), .val(val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_lo(alu_lo), .top(top), .next(next), .counter(counter),
        .busy(busy), .err(err)
    );

    // Stand-in for the shared ALU.
    always_comb begin
        case (alu_op)
            4'h0:    alu_lo = alu_a & alu_b;
            4'h1:    alu_lo = alu_a | alu_b;
            4'h4:    alu_lo = alu_a + alu_b;
            4'h6:    alu_lo = alu_a - alu_b;
            default: alu_lo = 32'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          k;
        logic [15:0] v;
        logic [1:0]  m;
        logic [15:0] e_top;
        logic [15:0] e_next;
        int          e_cnt;
        logic        e_err;
        int          e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int k, logic [15:0] v, logic [1:0] m, logic [15:0] et,
                                logic [15:0] en, int ec, logic ee, int eb);
        vec_t x;
        x.k = k; x.v = v; x.m = m; x.e_top = et; x.e_next = en;
        x.e_cnt = ec; x.e_err = ee; x.e_busy = eb;
        vecs.push_back(x);
    endfunction

    // Reference model: stack as a queue, back is top of stack.
    logic [15:0] q[$];
    logic        m_err;

    function automatic logic [3:0] exp_op(logic [1:0] m);
        case (m)
            2'd0:    return 4'h4;
            2'd1:    return 4'h6;
            2'd2:    return 4'h0;
            default: return 4'h1;
        endcase
    endfunction

    function automatic void model(int k, logic [15:0] v, logic [1:0] m);
        logic [15:0] a, b, r;
        case (k)
            0: if (q.size() < DEPTH) begin q.push_back(v); m_err = 1'b0; end
               else m_err = 1'b1;
            1: if (q.size() > 0) begin void'(q.pop_back()); m_err = 1'b0; end
               else m_err = 1'b1;
            2: if (q.size() >= 2) begin
                   b = q.pop_back();
                   a = q.pop_back();
                   case (m)
                       2'd0:    r = a + b;
                       2'd1:    r = a - b;
                       2'd2:    r = a & b;
                       default: r = a | b;
                   endcase
                   q.push_back(r);
                   m_err = 1'b0;
               end else m_err = 1'b1;
            default: if (q.size() >= 2) begin
                   a = q[q.size()-1];
                   q[q.size()-1] = q[q.size()-2];
                   q[q.size()-2] = a;
                   m_err = 1'b0;
               end else m_err = 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        key = 4'hF;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q.delete();
        m_err = 1'b0;
    endtask

    task automatic apply(input int k, input logic [15:0] v, input logic [1:0] m, output int bcnt);
        @(negedge clk);
        val = v;
        mode = m;
        key[k] = 1'b0;
        repeat (3) @(negedge clk);
        key[k] = 1'b1;
        bcnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int bc;
        int t;
        rst = 1'b1;
        key = 4'hF;
        val = '0;
        mode = 2'd0;
        m_err = 1'b0;
        #1;
        chk("rst_top", 32'(top), 0);
        chk("rst_next", 32'(next), 0);
        chk("rst_cnt", 32'(counter), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", 32'(alu_op), 4);
        chk("rst_shamt", 32'(alu_shamt), 0);
        do_reset();

        // Directed table: add, sub with wrap, swap then sub, underflow, and/or, overflow.
        add(0, 16'h0003, 0, 16'h0003, 16'h0000, 1, 0, 0);
        add(0, 16'h0005, 0, 16'h0005, 16'h0003, 2, 0, 0);
        add(2, 16'h0000, 0, 16'h0008, 16'h0000, 1, 0, 3);
        add(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 16'h0002, 0, 16'h0002, 16'h0000, 1, 0, 0);
        add(0, 16'h0005, 0, 16'h0005, 16'h0002, 2, 0, 0);
        add(2, 16'h0000, 1, 16'hFFFD, 16'h0000, 1, 0, 3);
        add(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 16'h0002, 0, 16'h0002, 16'h0000, 1, 0, 0);
        add(0, 16'h0005, 0, 16'h0005, 16'h0002, 2, 0, 0);
        add(3, 16'h0000, 0, 16'h0002, 16'h0005, 2, 0, 0);
        add(2, 16'h0000, 1, 16'h0003, 16'h0000, 1, 0, 3);
        add(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 16'h0001, 0, 16'h0001, 16'h0000, 1, 0, 0);
        add(2, 16'h0000, 0, 16'h0001, 16'h0000, 1, 1, 0);
        add(3, 16'h0000, 0, 16'h0001, 16'h0000, 1, 1, 0);
        add(0, 16'h0006, 0, 16'h0006, 16'h0001, 2, 0, 0);
        add(2, 16'h0000, 2, 16'h0000, 16'h0000, 1, 0, 3);
        add(0, 16'h000C, 0, 16'h000C, 16'h0000, 2, 0, 0);
        add(2, 16'h0000, 3, 16'h000C, 16'h0000, 1, 0, 3);
        add(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(0, 16'(i), 0, 16'(i), 16'(i - 1), i, 0, 0);
        add(0, 16'h0009, 0, 16'h0008, 16'h0007, 8, 1, 0);
        add(1, 16'h0000, 0, 16'h0007, 16'h0006, 7, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].k, vecs[i].v, vecs[i].m, bc);
            chk($sformatf("v%0d_top", i), 32'(top), 32'(vecs[i].e_top));
            chk($sformatf("v%0d_next", i), 32'(next), 32'(vecs[i].e_next));
            chk($sformatf("v%0d_cnt", i), 32'(counter), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_busy", i), 32'(bc), 32'(vecs[i].e_busy));
            if (vecs[i].e_busy == 3)
                chk($sformatf("v%0d_op", i), 32'(alu_op), 32'(exp_op(vecs[i].m)));
        end

        // Simultaneous push and pop: push wins.
        do_reset();
        apply(0, 16'h000A, 0, bc);
        @(negedge clk);
        val = 16'h000B;
        key[0] = 1'b0;
        key[1] = 1'b0;
        repeat (3) @(negedge clk);
        key = 4'hF;
        repeat (14) @(negedge clk);
        chk("prio_cnt", 32'(counter), 2);
        chk("prio_top", 32'(top), 32'h000B);
        chk("prio_next", 32'(next), 32'h000A);

        // Held key yields exactly one push.
        val = 16'h000C;
        key[0] = 1'b0;
        repeat (20) @(negedge clk);
        key[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_cnt", 32'(counter), 3);
        chk("held_top", 32'(top), 32'h000C);

        // Reset during EXEC of 4 + 6 aborts the writeback.
        do_reset();
        apply(0, 16'h0004, 0, bc);
        apply(0, 16'h0006, 0, bc);
        @(negedge clk);
        mode = 2'd0;
        key[2] = 1'b0;
        repeat (3) @(negedge clk);
        key[2] = 1'b1;
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_busy_seen", 32'(busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_cnt", 32'(counter), 0);
        chk("mid_top", 32'(top), 0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 16'h0007, 0, bc);
        chk("mid_push_top", 32'(top), 7);
        chk("mid_push_cnt", 32'(counter), 1);
        chk("mid_push_err", 32'(err), 0);

        // Random commands against the queue model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int r, k;
            logic [15:0] v;
            logic [1:0] m;
            logic ok_exec;
            logic [15:0] ea, eb;
            r = $urandom_range(0, 9);
            k = (r < 4) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : 3;
            v = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            ok_exec = (k == 2) && (q.size() >= 2);
            ea = (q.size() >= 2) ? q[q.size()-2] : 16'h0;
            eb = (q.size() >= 1) ? q[q.size()-1] : 16'h0;
            model(k, v, m);
            apply(k, v, m, bc);
            chk($sformatf("r%0d_top", i), 32'(top), (q.size() > 0) ? 32'(q[q.size()-1]) : 0);
            chk($sformatf("r%0d_next", i), 32'(next), (q.size() > 1) ? 32'(q[q.size()-2]) : 0);
            chk($sformatf("r%0d_cnt", i), 32'(counter), 32'(q.size()));
            chk($sformatf("r%0d_err", i), 32'(err), 32'(m_err));
            chk($sformatf("r%0d_busy", i), 32'(bc), ok_exec ? 3 : 0);
            if (ok_exec) begin
                chk($sformatf("r%0d_op", i), 32'(alu_op), 32'(exp_op(m)));
                chk($sformatf("r%0d_a", i), alu_a, 32'(ea));
                chk($sformatf("r%0d_b", i), alu_b, 32'(eb));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
